// File: rtl/usb_proxy_uart_pkg.sv
// rtl/usb_proxy_uart_pkg.sv - shared FSM states, ASCII constants and baud divider helper for the UART proxy
package usb_proxy_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  // Framing characters emitted by the descriptor forwarder
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_RBRACKET = 8'h5D;
  localparam logic [7:0] ASCII_LBRACE   = 8'h7B;
  localparam logic [7:0] ASCII_RBRACE   = 8'h7D;
  localparam logic [7:0] ASCII_COMMA    = 8'h2C;
  localparam logic [7:0] ASCII_NEWLINE  = 8'h0A;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with registered read port and occupancy count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == DEPTH_LVL);
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_q;
  assign level   = level_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not flushed on reset; clearing pointers and count is enough
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        dout_q   <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/usb_desc_uart_tx.sv
// rtl/usb_desc_uart_tx.sv - buffered 8N1 UART transmitter for the HID descriptor stream
// Define UART_TX_PARITY_EN to append an even parity bit (11-bit frame).
module usb_desc_uart_tx
  import usb_proxy_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 60000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        overflow_q;
  logic        bit_done;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;

  // Ready depends only on the registered count, so a pop cannot open a slot in the same cycle
  assign in_ready  = !rst && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign tx_busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow  = overflow_q;
  assign bit_done  = (timer_q == BIT_LAST);

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_START;
      ST_START: if (bit_done) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_done && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_done) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (state_q == ST_LOAD) begin
      parity_q <= ^fifo_dout;
    end
  end
`endif

  always_comb begin
    uart_txd = 1'b1;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE:   fifo_pop = !fifo_empty;
      ST_START:  uart_txd = 1'b0;
      ST_DATA:   uart_txd = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: uart_txd = parity_q;
`endif
      default:   uart_txd = 1'b1;
    endcase
  end

  // Bit timer runs only while a line bit is being held
  always_comb begin
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if ((state_q == ST_IDLE) || (state_q == ST_LOAD)) begin
      timer_d = '0;
    end else begin
      timer_d = bit_done ? '0 : timer_q + TW'(1);
    end
    if (state_q == ST_LOAD) begin
      shift_d = fifo_dout;
      idx_d   = 3'd0;
    end else if ((state_q == ST_DATA) && bit_done) begin
      shift_d = {1'b0, shift_q[7:1]};
      idx_d   = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      if (in_valid && fifo_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_desc_uart_tx.sv
// tb/tb_usb_desc_uart_tx.sv - directed self-checking bench for usb_desc_uart_tx
module tb_usb_desc_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int CPB      = 10;
  localparam int STOP_MID = (FB - 1) * CPB + 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, uart_txd, tx_busy, overflow;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mon_q[$];
  int         start_q[$];
  logic [7:0] exp_q[$];

  usb_desc_uart_tx #(
    .CLK_FREQ_HZ (1000),
    .BAUD_RATE   (100),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_mon(input int n, input int budget);
    int k = 0;
    while ((mon_q.size() < n) && (k < budget)) begin
      step();
      k++;
    end
    chk("mon_count", mon_q.size(), n);
  endtask

  // UART line decoder, samples mid-bit on the falling clock edge
  initial begin
    int         m_cnt = 0;
    logic       m_act = 1'b0;
    logic [7:0] m_sh = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        if (uart_txd === 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
          start_q.push_back(cyc);
        end
      end else begin
        m_cnt++;
        if (m_cnt == 5) begin
          chk("mon_start_bit", uart_txd, 1'b0);
        end else if ((m_cnt >= 15) && (m_cnt <= 85) && ((m_cnt % 10) == 5)) begin
          m_sh = {uart_txd, m_sh[7:1]};
`ifdef UART_TX_PARITY_EN
        end else if (m_cnt == 95) begin
          chk("mon_parity_bit", uart_txd, ^m_sh);
`endif
        end else if (m_cnt == STOP_MID) begin
          chk("mon_stop_bit", uart_txd, 1'b1);
          mon_q.push_back(m_sh);
          m_act = 1'b0;
        end
      end
    end
  end

  initial begin
    int         n;
    int         p;
    int         p2;
    int         sent;
    int         limit;
    logic [10:0] fr;

    // Reset state
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_txd", uart_txd, 1'b1);

    // 1: single 0x5B frame, exact waveform and latency
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, 1'b1, 8'h5B, 1'b0};
`else
    fr = {1'b0, 1'b1, 8'h5B, 1'b0};
`endif
    in_data = 8'h5B;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_level_after_push", fifo_level, 3'd1);
    chk("t1_busy_after_push", tx_busy, 1'b1);
    chk("t1_txd_n", uart_txd, 1'b1);
    step();
    chk("t1_level_after_pop", fifo_level, 3'd0);
    chk("t1_txd_n1", uart_txd, 1'b1);
    step();
    for (int b = 0; b < FB; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("t1_bit%0d_cyc%0d", b, c), uart_txd, fr[b]);
        step();
      end
    end
    chk("t1_busy_end", tx_busy, 1'b0);
    chk("t1_txd_end", uart_txd, 1'b1);
    wait_mon(1, 20);
    chk("t1_decoded", mon_q[0], 8'h5B);

    // 2: back-to-back frames and the inter-frame gap
    repeat (10) step();
    mon_q.delete();
    start_q.delete();
    in_data = 8'h7D;
    in_valid = 1'b1;
    step();
    in_data = 8'h0A;
    step();
    in_valid = 1'b0;
    wait_mon(2, 2 * (FB * CPB + 2) + 40);
    chk("t2_byte0", mon_q[0], 8'h7D);
    chk("t2_byte1", mon_q[1], 8'h0A);
    chk("t2_start_spacing", start_q[1] - start_q[0], FB * CPB + 2);
    chk("t2_overflow", overflow, 1'b0);

    // 3: seven cycles of in_valid into a depth-4 FIFO
    repeat (20) step();
    mon_q.delete();
    for (int i = 0; i < 7; i++) begin
      in_data = 8'(8'h30 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("t3_level", fifo_level, 3'd4);
    chk("t3_in_ready", in_ready, 1'b0);
    chk("t3_overflow", overflow, 1'b1);
    wait_mon(5, 5 * (FB * CPB + 2) + 40);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_byte%0d", i), mon_q[i], 8'(8'h30 + i));
    end
    repeat (200) step();
    chk("t3_frames_total", mon_q.size(), 5);
    chk("t3_overflow_sticky", overflow, 1'b1);
    chk("t3_busy_idle", tx_busy, 1'b0);

    // 4: reset during data bit 3 of 0x00 with a second byte queued
    mon_q.delete();
    in_data = 8'h00;
    in_valid = 1'b1;
    step();
    n = cyc;
    in_data = 8'h41;
    step();
    in_valid = 1'b0;
    chk("t4_level_queued", fifo_level, 3'd1);
    wait_until(n + 44);
    chk("t4_txd_bit3", uart_txd, 1'b0);
    rst = 1'b1;
    step();
    chk("t4_txd_after_rst", uart_txd, 1'b1);
    chk("t4_level_after_rst", fifo_level, 3'd0);
    chk("t4_busy_after_rst", tx_busy, 1'b0);
    chk("t4_overflow_after_rst", overflow, 1'b0);
    chk("t4_in_ready_in_rst", in_ready, 1'b0);
    rst = 1'b0;
    step();
    chk("t4_in_ready_released", in_ready, 1'b1);
    repeat (300) step();
    chk("t4_no_frames", mon_q.size(), 0);
    chk("t4_busy_quiet", tx_busy, 1'b0);

    // 5: push colliding with pop at level 2 and at level 4
    mon_q.delete();
    in_data = 8'h7B;
    in_valid = 1'b1;
    step();
    n = cyc;
    in_valid = 1'b0;
    wait_until(n + 9);
    in_data = 8'h2C;
    in_valid = 1'b1;
    step();
    in_data = 8'h7D;
    step();
    in_valid = 1'b0;
    chk("t5_level_two", fifo_level, 3'd2);
    p = n + FB * CPB + 3;
    wait_until(p - 1);
    chk("t5_level_pre_pop", fifo_level, 3'd2);
    in_data = 8'h0A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_level_push_pop", fifo_level, 3'd2);
    step();
    chk("t5_start_after_pop", uart_txd, 1'b0);
    wait_until(p + 9);
    in_data = 8'h5D;
    in_valid = 1'b1;
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    chk("t5_level_full", fifo_level, 3'd4);
    p2 = p + FB * CPB + 2;
    wait_until(p2 - 1);
    chk("t5_ready_full", in_ready, 1'b0);
    in_data = 8'h47;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_level_refused", fifo_level, 3'd3);
    chk("t5_overflow", overflow, 1'b1);
    wait_mon(6, 6 * (FB * CPB + 2) + 40);
    exp_q = '{8'h7B, 8'h2C, 8'h7D, 8'h0A, 8'h5D, 8'h22};
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t5_byte%0d", i), mon_q[i], exp_q[i]);
    end
    repeat (200) step();
    chk("t5_frames_total", mon_q.size(), 6);

    // 6: random stream, source honours in_ready
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mon_q.delete();
    exp_q.delete();
    sent = 0;
    limit = cyc + 256 * (FB * CPB + 2) + 2000;
    while ((sent < 256) && (cyc < limit)) begin
      if (in_ready && ($urandom_range(3) != 0)) begin
        in_data = 8'($urandom);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (in_valid) begin
        exp_q.push_back(in_data);
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("t6_sent", sent, 256);
    wait_mon(256, 8 * (FB * CPB + 2) + 100);
    for (int i = 0; i < 256; i++) begin
      if (i < mon_q.size()) begin
        chk($sformatf("t6_byte%0d", i), mon_q[i], exp_q[i]);
      end
    end
    chk("t6_overflow", overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
